vec_issue_seq: RTL and testbench
================================

Name: vec_issue_seq

Overview:
- Vector issue sequencer between vec_decode and the vector execute datapath.
- Owns the vl/vtype configuration state and executes vsetvli.
- Breaks each decoded vector arithmetic instruction into LANE_W-bit beats, issued to the execute unit over a valid/ready handshake.
- Stalls the scalar front end while an instruction is in flight.

Parameters:
- VLEN, 512, vector register length in bits.
- LANE_W, 128, execute datapath width in bits per beat; power of two, 32 <= LANE_W <= VLEN.
- BEAT_W, $clog2(8*VLEN/LANE_W)+1, beat counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_valid  in  1  decoded instruction present.
- inst_ready  out  1  sequencer can accept an instruction.
- is_vec  in  1  decoder vector-instruction flag.
- is_cfg  in  1  instruction is vsetvli.
- cfg_avl  in  32  AVL (scalar1).
- cfg_avl_max  in  1  rs1==x0 && rd!=x0: request vl=VLMAX.
- cfg_vtype  in  32  requested vtype (scalar2 / zimm).
- vl_o  out  32  current vl.
- vtype_o  out  32  current vtype; bit31 = vill.
- cfg_rd_data  out  32  new vl written to rd.
- cfg_rd_we  out  1  one-cycle rd write strobe.
- exe_valid  out  1  beat valid to execute unit.
- exe_ready  in  1  execute unit accepts beat.
- exe_beat  out  BEAT_W  beat index, starting at 0.
- exe_elems  out  $clog2(LANE_W/8)+1  active elements in this beat.
- exe_last  out  1  final beat of instruction.
- exe_sew  out  3  vsew field.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse: vector op issued while vill=1.
- stall  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous, on reset low): state=IDLE, vl_o=0, vtype_o=32'h8000_0000 (vill), all pulses/valids 0, beat counter 0.
- inst_ready = (state==IDLE). An instruction is accepted on inst_valid && inst_ready && is_vec. Non-vector instructions are ignored.
- vtype decode:
  - vsew = vtype[5:3]; legal values 0, 1, 2 give SEW 8, 16, 32.
  - vlmul = vtype[2:0]; legal values 0..3 give LMUL 1, 2, 4, 8.
  - vtype[31:8] must be 0.
  - Any illegal field sets vill: vtype_o=32'h8000_0000, vl=0.
- VLMAX = (VLEN/SEW)*LMUL. vl = cfg_avl_max ? VLMAX : min(cfg_avl, VLMAX).
- FSM states:
  - IDLE.
    - Accepted with is_cfg -> CFG.
    - Accepted without is_cfg: vill -> ERR; vl==0 -> DONE; otherwise -> ISSUE with beat=0.
  - CFG (1 cycle):
    - Register vl_o and vtype_o.
    - cfg_rd_data = new vl, cfg_rd_we=1.
    - Next state DONE.
  - ISSUE:
    - exe_valid=1.
    - exe_beat, exe_elems, exe_last and exe_sew stay stable until exe_ready.
    - On handshake: if exe_last -> DONE, else beat+1.
  - DONE (1 cycle): done=1, next state IDLE.
  - ERR (1 cycle): illegal=1, done=1, next state IDLE; exe_valid never asserts.
- Beat arithmetic:
  - total_bits = vl*SEW, computed with 32-bit intermediate.
  - nbeats = ceil(total_bits/LANE_W).
  - epb = LANE_W/SEW.
  - exe_elems = epb on every beat except the last, which gets vl - (nbeats-1)*epb.
  - exe_last = (beat == nbeats-1).
- vl/vtype are sampled at acceptance. A later vsetvli cannot be accepted until the current instruction reaches DONE.
- Reset mid-ISSUE aborts immediately: exe_valid drops asynchronously, config returns to reset values, and no done pulse is generated.

Test Plan (VLEN=512, LANE_W=128):
1. Reset: hold reset low, then release -> vl_o=0, vtype_o=0x80000000, inst_ready=1, stall=0.
2. vsetvli, cfg_avl=64, cfg_vtype=0x10 (SEW32, LMUL1):
   - cfg_rd_we pulses with cfg_rd_data=16.
   - vl_o=16, vtype_o=0x10.
   - done pulses exactly 2 cycles after acceptance.
3. Arithmetic op after test 2, exe_ready=1:
   - 4 consecutive beats 0..3, exe_elems=4 each, exe_last on beat 3.
   - done on the next cycle; stall high throughout.
4. Same op with exe_ready low 3 cycles during beat 1:
   - exe_beat=1 and all exe_* outputs held stable.
   - Completion is delayed exactly 3 cycles.
5. vsetvli, cfg_avl=10, vtype=0x00 (SEW8) -> vl=10; next op issues 1 beat with exe_elems=10 and exe_last=1.
6. Illegal config and reset abort:
   - vsetvli with vtype=0x18 (vsew=3) -> vill set, vl=0.
   - Next vector op -> illegal and done pulse, no exe_valid.
   - Separately, reset asserted during beat 2 -> immediate return to reset values, no done pulse.

Source files
------------

// File: rtl/vec_issue_seq_if.sv
// Bus between the vector issue sequencer and its neighbours:
// decoded-instruction handshake, vsetvli configuration, and execute beat handshake.
// The slave modport is the sequencer's view; master is the decoder/execute side.
interface vec_issue_seq_if #(
   parameter int VLEN   = 512,
   parameter int LANE_W = 128,
   parameter int BEAT_W = $clog2(8*VLEN/LANE_W)+1,
   parameter int EL_W   = $clog2(LANE_W/8)+1
);
   // decoded instruction handshake
   logic              inst_valid;
   logic              inst_ready;
   logic              is_vec;
   logic              is_cfg;
   // vsetvli operands and results
   logic [31:0]       cfg_avl;
   logic              cfg_avl_max;
   logic [31:0]       cfg_vtype;
   logic [31:0]       vl_o;
   logic [31:0]       vtype_o;
   logic [31:0]       cfg_rd_data;
   logic              cfg_rd_we;
   // execute beat handshake
   logic              exe_valid;
   logic              exe_ready;
   logic [BEAT_W-1:0] exe_beat;
   logic [EL_W-1:0]   exe_elems;
   logic              exe_last;
   logic [2:0]        exe_sew;
   // status
   logic              done;
   logic              illegal;
   logic              stall;

   modport slave (
      input  inst_valid, is_vec, is_cfg, cfg_avl, cfg_avl_max, cfg_vtype, exe_ready,
      output inst_ready, vl_o, vtype_o, cfg_rd_data, cfg_rd_we,
      output exe_valid, exe_beat, exe_elems, exe_last, exe_sew,
      output done, illegal, stall
   );

   modport master (
      output inst_valid, is_vec, is_cfg, cfg_avl, cfg_avl_max, cfg_vtype, exe_ready,
      input  inst_ready, vl_o, vtype_o, cfg_rd_data, cfg_rd_we,
      input  exe_valid, exe_beat, exe_elems, exe_last, exe_sew,
      input  done, illegal, stall
   );
endinterface

// File: rtl/vec_issue_seq.sv
// Vector issue sequencer: holds vl/vtype, executes vsetvli, and splits each
// vector arithmetic instruction into LANE_W-bit beats for the execute unit.
// The scalar front end is stalled whenever the sequencer is not idle.
module vec_issue_seq #(
   parameter int VLEN   = 512,
   parameter int LANE_W = 128,
   parameter int BEAT_W = $clog2(8*VLEN/LANE_W)+1
) (
   input logic            clk,
   input logic            reset,   // asynchronous, active low
   vec_issue_seq_if.slave bus
);
   localparam int          EL_W    = $clog2(LANE_W/8)+1;
   localparam int          LANE_SH = $clog2(LANE_W);
   localparam logic [31:0] VILL    = 32'h8000_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG,
      S_ISSUE,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       vl_q, vl_d;
   logic [31:0]       vtype_q, vtype_d;
   // configuration computed at vsetvli acceptance, committed in CFG
   logic [31:0]       new_vl_q, new_vl_d;
   logic [31:0]       new_vtype_q, new_vtype_d;
   // beat bookkeeping for the instruction in flight
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [BEAT_W-1:0] nbeats_q, nbeats_d;
   logic [EL_W-1:0]   epb_q, epb_d;
   logic [EL_W-1:0]   last_elems_q, last_elems_d;

   logic              accept;
   logic              is_last;

   // requested-configuration decode
   logic [2:0]        req_sew;
   logic [2:0]        req_lmul;
   logic              req_legal;
   logic [31:0]       req_vlmax;
   logic [31:0]       req_vl;

   // beat arithmetic for the current configuration
   logic [2:0]        cur_sew;
   logic [31:0]       total_bits;
   logic [31:0]       nbeats_full;
   logic [31:0]       epb_full;

   // Decode the vtype/AVL of an incoming vsetvli into the vl it would produce.
   always_comb begin
      req_sew   = bus.cfg_vtype[5:3];
      req_lmul  = bus.cfg_vtype[2:0];
      req_legal = (bus.cfg_vtype[31:8] == 24'd0) && (req_sew <= 3'd2) && (req_lmul <= 3'd3);
      // VLMAX = (VLEN/SEW)*LMUL with SEW = 8 << vsew and LMUL = 1 << vlmul
      req_vlmax = (32'(VLEN) >> ({1'b0, req_sew} + 4'd3)) << req_lmul;
      if (!req_legal) begin
         req_vl = 32'd0;
      end else if (bus.cfg_avl_max) begin
         req_vl = req_vlmax;
      end else if (bus.cfg_avl < req_vlmax) begin
         req_vl = bus.cfg_avl;
      end else begin
         req_vl = req_vlmax;
      end
   end

   // Beat count, elements per beat and the tail size for the current vl/vtype.
   always_comb begin
      cur_sew     = vtype_q[5:3];
      total_bits  = vl_q << ({1'b0, cur_sew} + 4'd3);
      nbeats_full = (total_bits + 32'(LANE_W - 1)) >> LANE_SH;
      epb_full    = 32'(LANE_W) >> ({1'b0, cur_sew} + 4'd3);
      is_last     = (beat_q == nbeats_q - BEAT_W'(1));
   end

   // Next-state logic and all handshake/status outputs.
   always_comb begin
      state_d      = state_q;
      vl_d         = vl_q;
      vtype_d      = vtype_q;
      new_vl_d     = new_vl_q;
      new_vtype_d  = new_vtype_q;
      beat_d       = beat_q;
      nbeats_d     = nbeats_q;
      epb_d        = epb_q;
      last_elems_d = last_elems_q;

      accept          = 1'b0;
      bus.inst_ready  = 1'b0;
      bus.stall       = 1'b1;
      bus.cfg_rd_we   = 1'b0;
      bus.cfg_rd_data = new_vl_q;
      bus.exe_valid   = 1'b0;
      bus.done        = 1'b0;
      bus.illegal     = 1'b0;

      case (state_q)
         S_IDLE: begin
            bus.inst_ready = 1'b1;
            bus.stall      = 1'b0;
            accept         = bus.inst_valid && bus.is_vec;
            if (accept) begin
               if (bus.is_cfg) begin
                  new_vl_d    = req_vl;
                  new_vtype_d = req_legal ? bus.cfg_vtype : VILL;
                  state_d     = S_CFG;
               end else if (vtype_q[31]) begin
                  state_d = S_ERR;
               end else if (vl_q == 32'd0) begin
                  state_d = S_DONE;
               end else begin
                  // snapshot the beat plan so it stays fixed for the whole instruction
                  beat_d       = '0;
                  nbeats_d     = BEAT_W'(nbeats_full);
                  epb_d        = EL_W'(epb_full);
                  last_elems_d = EL_W'(vl_q - (nbeats_full - 32'd1) * epb_full);
                  state_d      = S_ISSUE;
               end
            end
         end
         S_CFG: begin
            bus.cfg_rd_we = 1'b1;
            vl_d          = new_vl_q;
            vtype_d       = new_vtype_q;
            state_d       = S_DONE;
         end
         S_ISSUE: begin
            bus.exe_valid = 1'b1;
            if (bus.exe_ready) begin
               if (is_last) begin
                  state_d = S_DONE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         S_ERR: begin
            bus.illegal = 1'b1;
            bus.done    = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Beat payload is held straight from registers so it is stable under backpressure.
   always_comb begin
      bus.vl_o      = vl_q;
      bus.vtype_o   = vtype_q;
      bus.exe_beat  = beat_q;
      bus.exe_last  = is_last;
      bus.exe_elems = is_last ? last_elems_q : epb_q;
      bus.exe_sew   = vtype_q[5:3];
   end

   // State and configuration registers; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         vl_q         <= 32'd0;
         vtype_q      <= VILL;
         new_vl_q     <= 32'd0;
         new_vtype_q  <= VILL;
         beat_q       <= '0;
         nbeats_q     <= '0;
         epb_q        <= '0;
         last_elems_q <= '0;
      end else begin
         state_q      <= state_d;
         vl_q         <= vl_d;
         vtype_q      <= vtype_d;
         new_vl_q     <= new_vl_d;
         new_vtype_q  <= new_vtype_d;
         beat_q       <= beat_d;
         nbeats_q     <= nbeats_d;
         epb_q        <= epb_d;
         last_elems_q <= last_elems_d;
      end
   end

endmodule

// File: tb/tb_vec_issue_seq.sv
// Directed bench for vec_issue_seq. A behavioural model derives the expected
// per-cycle outputs of each vsetvli / vector op from vl/vtype arithmetic, and
// each driven cycle is compared against it mid-cycle.
module tb_vec_issue_seq;
   localparam int VLEN   = 512;
   localparam int LANE_W = 128;

   typedef struct {
      logic        ready;
      logic        stall;
      logic        valid;
      logic [31:0] beat;
      logic [31:0] elems;
      logic        last;
      logic [31:0] sew;
      logic        done;
      logic        ill;
      logic        rd_we;
      logic [31:0] rd_data;
      logic [31:0] vl;
      logic [31:0] vtype;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   vec_issue_seq_if #(.VLEN(VLEN), .LANE_W(LANE_W)) bus ();

   vec_issue_seq #(.VLEN(VLEN), .LANE_W(LANE_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int          n_vec   = 0;
   int          n_miss  = 0;
   bit          cyc_bad = 1'b0;
   string       tag     = "init";
   logic [31:0] m_vl    = 32'd0;
   logic [31:0] m_vtype = 32'h8000_0000;

   function automatic exp_t idle_exp();
      exp_t e;
      e.ready = 1'b1; e.stall = 1'b0; e.valid = 1'b0;
      e.beat = 32'd0; e.elems = 32'd0; e.last = 1'b0; e.sew = 32'd0;
      e.done = 1'b0; e.ill = 1'b0; e.rd_we = 1'b0; e.rd_data = 32'd0;
      e.vl = m_vl; e.vtype = m_vtype;
      return e;
   endfunction

   function automatic exp_t busy_exp();
      exp_t e;
      e = idle_exp();
      e.ready = 1'b0;
      e.stall = 1'b1;
      return e;
   endfunction

   task automatic fld(input string f, input logic [31:0] got, input logic [31:0] want);
      if (got !== want) begin
         $display("FAIL %s.%s got 0x%0h want 0x%0h", tag, f, got, want);
         cyc_bad = 1'b1;
      end
   endtask

   task automatic compare(input exp_t e);
      cyc_bad = 1'b0;
      fld("inst_ready", 32'(bus.inst_ready), 32'(e.ready));
      fld("stall",      32'(bus.stall),      32'(e.stall));
      fld("exe_valid",  32'(bus.exe_valid),  32'(e.valid));
      if (e.valid) begin
         fld("exe_beat",  32'(bus.exe_beat),  e.beat);
         fld("exe_elems", 32'(bus.exe_elems), e.elems);
         fld("exe_last",  32'(bus.exe_last),  32'(e.last));
         fld("exe_sew",   32'(bus.exe_sew),   e.sew);
      end
      fld("done",      32'(bus.done),      32'(e.done));
      fld("illegal",   32'(bus.illegal),   32'(e.ill));
      fld("cfg_rd_we", 32'(bus.cfg_rd_we), 32'(e.rd_we));
      if (e.rd_we) fld("cfg_rd_data", bus.cfg_rd_data, e.rd_data);
      fld("vl_o",    bus.vl_o,    e.vl);
      fld("vtype_o", bus.vtype_o, e.vtype);
      n_vec++;
      if (cyc_bad) n_miss++;
   endtask

   task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         $display("FAIL %s got 0x%0h want 0x%0h", name, got, want);
         n_miss++;
      end
   endtask

   // drive one cycle's inputs just after the rising edge, check mid-cycle
   task automatic cyc(input logic iv, input logic vec, input logic cfg, input logic [31:0] avl,
                      input logic amax, input logic [31:0] vt, input logic rdy, input exp_t e);
      @(posedge clk);
      #1;
      bus.inst_valid  = iv;
      bus.is_vec      = vec;
      bus.is_cfg      = cfg;
      bus.cfg_avl     = avl;
      bus.cfg_avl_max = amax;
      bus.cfg_vtype   = vt;
      bus.exe_ready   = rdy;
      @(negedge clk);
      compare(e);
   endtask

   task automatic idle_cyc(input logic rdy, input exp_t e);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy, e);
   endtask

   // vsetvli: accept, CFG (rd write), DONE; model config updates after CFG
   task automatic run_cfg(input logic [31:0] avl, input logic amax, input logic [31:0] vt,
                          output logic [31:0] nvl);
      exp_t        e;
      logic        legal;
      logic [31:0] vlmax;
      logic [31:0] nvt;
      legal = (vt[31:8] == 24'd0) && (vt[5:3] <= 3'd2) && (vt[2:0] <= 3'd3);
      if (legal) begin
         vlmax = (VLEN / (8 * (1 << vt[5:3]))) * (1 << vt[2:0]);
         nvl   = amax ? vlmax : ((avl < vlmax) ? avl : vlmax);
         nvt   = vt;
      end else begin
         nvl = 32'd0;
         nvt = 32'h8000_0000;
      end
      cyc(1'b1, 1'b1, 1'b1, avl, amax, vt, 1'b1, idle_exp());
      e = busy_exp();
      e.rd_we   = 1'b1;
      e.rd_data = nvl;
      // scramble the config inputs: the result must come from acceptance time
      cyc(1'b0, 1'b1, 1'b1, 32'h0000_FFFF, 1'b1, 32'h0000_0007, 1'b1, e);
      m_vl    = nvl;
      m_vtype = nvt;
      e = busy_exp();
      e.done = 1'b1;
      idle_cyc(1'b1, e);
   endtask

   // vector op: optional exe_ready-low stretch of stall_n cycles on beat stall_beat
   task automatic run_op(input int stall_beat, input int stall_n,
                         output int lat, output int nb, output int last_el);
      exp_t e;
      int   mv, sewb, epb, rem;
      mv      = int'(m_vl);
      lat     = 0;
      nb      = 0;
      last_el = 0;
      cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, idle_exp());
      if (m_vtype[31]) begin
         e = busy_exp();
         e.done = 1'b1;
         e.ill  = 1'b1;
         idle_cyc(1'b1, e);
         lat = 1;
      end else if (mv == 0) begin
         e = busy_exp();
         e.done = 1'b1;
         idle_cyc(1'b1, e);
         lat = 1;
      end else begin
         sewb = 8 << m_vtype[5:3];
         nb   = (mv * sewb + LANE_W - 1) / LANE_W;
         epb  = LANE_W / sewb;
         for (int b = 0; b < nb; b++) begin
            rem     = mv - b * epb;
            e       = busy_exp();
            e.valid = 1'b1;
            e.beat  = 32'(b);
            e.elems = 32'((rem < epb) ? rem : epb);
            e.last  = (b == nb - 1);
            e.sew   = 32'(m_vtype[5:3]);
            last_el = int'(e.elems);
            if (b == stall_beat) begin
               for (int k = 0; k < stall_n; k++) begin
                  idle_cyc(1'b0, e);
                  lat++;
               end
            end
            idle_cyc(1'b1, e);
            lat++;
         end
         e = busy_exp();
         e.done = 1'b1;
         idle_cyc(1'b1, e);
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] nvl;
      int          lat, nb, lel;
      exp_t        e;

      bus.inst_valid  = 1'b0;
      bus.is_vec      = 1'b0;
      bus.is_cfg      = 1'b0;
      bus.cfg_avl     = 32'd0;
      bus.cfg_avl_max = 1'b0;
      bus.cfg_vtype   = 32'd0;
      bus.exe_ready   = 1'b1;

      // 1. reset
      tag = "reset_hold";
      repeat (2) idle_cyc(1'b1, idle_exp());
      reset = 1'b1;
      tag = "reset";
      idle_cyc(1'b1, idle_exp());
      pin("reset_vl_o", bus.vl_o, 32'd0);
      pin("reset_vtype_o", bus.vtype_o, 32'h8000_0000);

      // non-vector instruction is ignored
      tag = "nonvec";
      cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, idle_exp());
      idle_cyc(1'b1, idle_exp());

      // 2. vsetvli SEW32 LMUL1, avl 64 -> vl 16
      tag = "t2_cfg";
      run_cfg(32'd64, 1'b0, 32'h10, nvl);
      pin("t2_model_vl", nvl, 32'd16);
      pin("t2_vl_o", bus.vl_o, 32'd16);
      pin("t2_vtype_o", bus.vtype_o, 32'h10);

      // 3. op with exe_ready=1: 4 beats of 4
      tag = "t3_op";
      run_op(-1, 0, lat, nb, lel);
      pin("t3_latency", 32'(lat), 32'd5);
      pin("t3_nbeats", 32'(nb), 32'd4);
      pin("t3_last_elems", 32'(lel), 32'd4);

      // 4. same op, exe_ready low 3 cycles on beat 1
      tag = "t4_stall";
      run_op(1, 3, lat, nb, lel);
      pin("t4_latency", 32'(lat), 32'd8);

      // 5. SEW8 avl 10 -> single beat of 10
      tag = "t5_cfg";
      run_cfg(32'd10, 1'b0, 32'h00, nvl);
      pin("t5_model_vl", nvl, 32'd10);
      tag = "t5_op";
      run_op(-1, 0, lat, nb, lel);
      pin("t5_nbeats", 32'(nb), 32'd1);
      pin("t5_last_elems", 32'(lel), 32'd10);

      // partial tail: SEW16 avl 13 -> beats of 8 and 5
      tag = "tail_cfg";
      run_cfg(32'd13, 1'b0, 32'h08, nvl);
      tag = "tail_op";
      run_op(0, 2, lat, nb, lel);
      pin("tail_nbeats", 32'(nb), 32'd2);
      pin("tail_last_elems", 32'(lel), 32'd5);

      // VLMAX request: SEW16 LMUL2 -> vl 64, 8 beats
      tag = "vlmax_cfg";
      run_cfg(32'd0, 1'b1, 32'h09, nvl);
      pin("vlmax_model_vl", nvl, 32'd64);
      tag = "vlmax_op";
      run_op(7, 1, lat, nb, lel);
      pin("vlmax_nbeats", 32'(nb), 32'd8);

      // legal config with vl 0: op completes with no beats
      tag = "vl0_cfg";
      run_cfg(32'd0, 1'b0, 32'h10, nvl);
      tag = "vl0_op";
      run_op(-1, 0, lat, nb, lel);
      pin("vl0_latency", 32'(lat), 32'd1);

      // 6a. illegal vsew -> vill, then op flags illegal
      tag = "t6_vill_cfg";
      run_cfg(32'd5, 1'b0, 32'h18, nvl);
      pin("t6_model_vl", nvl, 32'd0);
      pin("t6_vtype_o", bus.vtype_o, 32'h8000_0000);
      tag = "t6_vill_op";
      run_op(-1, 0, lat, nb, lel);
      pin("t6_latency", 32'(lat), 32'd1);

      // illegal LMUL also sets vill
      tag = "lmul_cfg";
      run_cfg(32'd5, 1'b0, 32'h14, nvl);
      tag = "lmul_op";
      run_op(-1, 0, lat, nb, lel);

      // 6b. reset during beat 2 aborts immediately
      tag = "t6_rst_cfg";
      run_cfg(32'd64, 1'b0, 32'h10, nvl);
      tag = "t6_rst_op";
      cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, idle_exp());
      for (int b = 0; b < 3; b++) begin
         e       = busy_exp();
         e.valid = 1'b1;
         e.beat  = 32'(b);
         e.elems = 32'd4;
         e.last  = 1'b0;
         e.sew   = 32'd2;
         idle_cyc(1'b1, e);
      end
      reset = 1'b0;
      #1;
      pin("abort_exe_valid", 32'(bus.exe_valid), 32'd0);
      pin("abort_vl_o", bus.vl_o, 32'd0);
      pin("abort_vtype_o", bus.vtype_o, 32'h8000_0000);
      pin("abort_stall", 32'(bus.stall), 32'd0);
      pin("abort_done", 32'(bus.done), 32'd0);
      m_vl    = 32'd0;
      m_vtype = 32'h8000_0000;
      tag = "t6_rst_hold";
      repeat (2) idle_cyc(1'b1, idle_exp());
      reset = 1'b1;
      tag = "t6_rst_after";
      idle_cyc(1'b1, idle_exp());

      // recovery after abort
      tag = "recover_cfg";
      run_cfg(32'd6, 1'b0, 32'h10, nvl);
      tag = "recover_op";
      run_op(-1, 0, lat, nb, lel);
      pin("recover_last_elems", 32'(lel), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
